// File: rtl/vram_pkg.sv
// vram_pkg: shared VRAM types, default geometry and the address-map helper.
//   vram_state_t : IDLE / CLEAR sweep states
//   vram_loc_t   : {bank_sel, index} result of vram_map()
//   VRAM_*       : default data width and bank depths used by the raster fetch logic
package vram_pkg;

    localparam int VRAM_DATA_W      = 8;
    localparam int VRAM_LOWER_DEPTH = 4096;
    localparam int VRAM_UPPER_DEPTH = 2048;

    typedef enum logic {IDLE, CLEAR} vram_state_t;

    typedef struct packed {
        logic        bank_sel;
        logic [30:0] index;
    } vram_loc_t;

    // The top address bit picks the bank. The upper bank keeps only log2(upper_depth)
    // index bits, which makes it repeat across the upper half of the space.
    function automatic vram_loc_t vram_map(input logic [30:0] addr, input int addr_w,
                                           input int upper_depth);
        vram_loc_t loc;
        loc.bank_sel = addr[addr_w-1];
        loc.index    = loc.bank_sel ? (addr & 31'(upper_depth - 1))
                                    : (addr & 31'((1 << (addr_w - 1)) - 1));
        return loc;
    endfunction

endpackage

// File: rtl/vram_mirrored_banks_if.sv
// vram_mirrored_banks_if: host write, host read and display read bus of the VRAM.
//   master : host/raster side (drives addresses, data and requests)
//   slave  : VRAM side (drives wrReady, read data, hostRdValid, busy)
interface vram_mirrored_banks_if
    import vram_pkg::*;
#(
    parameter int DATA_W = VRAM_DATA_W,
    parameter int ADDR_W = $clog2(VRAM_LOWER_DEPTH) + 1
);
    logic [ADDR_W-1:0] wrAddr;
    logic [DATA_W-1:0] wrData;
    logic              wrReq;
    logic              wrReady;
    logic [ADDR_W-1:0] hostRdAddr;
    logic              hostRdReq;
    logic [DATA_W-1:0] hostRdData;
    logic              hostRdValid;
    logic [ADDR_W-1:0] dispRdAddr;
    logic [DATA_W-1:0] dispRdData;
    logic              busy;

    modport master (
        output wrAddr, wrData, wrReq, hostRdAddr, hostRdReq, dispRdAddr,
        input  wrReady, hostRdData, hostRdValid, dispRdData, busy
    );

    modport slave (
        input  wrAddr, wrData, wrReq, hostRdAddr, hostRdReq, dispRdAddr,
        output wrReady, hostRdData, hostRdValid, dispRdData, busy
    );
endinterface

// File: rtl/vram_bank.sv
// vram_bank: one simple-dual-port storage copy, read-first, no storage reset.
//   clk               : clock
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i      : read enable / address; rdata_o holds while re_i=0
//   rdata_o           : registered read data (latency 1)
module vram_bank #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4096
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [DATA_W-1:0]        rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Both statements are non-blocking, so a same-edge read of the written word sees the old data.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/vram_mirrored_banks.sv
// vram_mirrored_banks: VRAM with a lower bank and an upper bank that is mirrored across the upper half.
//   clk   : clock, all logic on posedge
//   rst_n : asynchronous active-low reset
//   bus   : vram_mirrored_banks_if.slave (host write, host read handshake, free-running display read, busy)
// Every write lands in a host copy and a display copy of each bank.
// Optional macro VRAM_CLEAR_EN: after reset, sweep CLEAR_VALUE through every word before accepting traffic.
module vram_mirrored_banks
    import vram_pkg::*;
#(
    parameter int              DATA_W      = VRAM_DATA_W,
    parameter int              LOWER_DEPTH = VRAM_LOWER_DEPTH,
    parameter int              UPPER_DEPTH = VRAM_UPPER_DEPTH,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input logic                  clk,
    input logic                  rst_n,
    vram_mirrored_banks_if.slave bus
);
    localparam int ADDR_W = $clog2(LOWER_DEPTH) + 1;
    localparam int LA_W   = ADDR_W - 1;
    localparam int UA_W   = $clog2(UPPER_DEPTH);

    logic              clearing;
    logic [LA_W-1:0]   clr_idx;
    logic              busy;
    logic              wr_ready;

`ifdef VRAM_CLEAR_EN
    vram_state_t       state_q;
    logic [LA_W-1:0]   cnt_q;
    logic              busy_q;
    logic              wr_ready_q;

    // Sweep ends on the edge after the last index; the counter wraps back to 0 there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            wr_ready_q <= 1'b0;
        end else if (state_q == CLEAR) begin
            cnt_q <= cnt_q + 1'b1;
            if (&cnt_q) begin
                state_q    <= IDLE;
                busy_q     <= 1'b0;
                wr_ready_q <= 1'b1;
            end
        end
    end

    assign clearing = (state_q == CLEAR);
    assign clr_idx  = cnt_q;
    assign busy     = busy_q;
    assign wr_ready = wr_ready_q;
`else
    assign clearing = 1'b0;
    assign clr_idx  = '0;
    assign busy     = 1'b0;
    assign wr_ready = 1'b1;
`endif

    vram_loc_t wr_loc;
    vram_loc_t host_loc;
    vram_loc_t disp_loc;

    assign wr_loc   = vram_map(31'(bus.wrAddr), ADDR_W, UPPER_DEPTH);
    assign host_loc = vram_map(31'(bus.hostRdAddr), ADDR_W, UPPER_DEPTH);
    assign disp_loc = vram_map(31'(bus.dispRdAddr), ADDR_W, UPPER_DEPTH);

    // Index bits above the lower-bank width are always zero from vram_map.
    logic unused_map;
    assign unused_map = ^{wr_loc.index[30:LA_W], host_loc.index[30:LA_W], disp_loc.index[30:LA_W]};

    logic              wr_acc;
    logic              host_acc;
    logic              lo_we;
    logic              up_we;
    logic [LA_W-1:0]   lo_waddr;
    logic [UA_W-1:0]   up_waddr;
    logic [DATA_W-1:0] wdata;

    assign wr_acc   = bus.wrReq & wr_ready;
    assign host_acc = bus.hostRdReq & ~clearing;
    assign lo_we    = clearing | (wr_acc & ~wr_loc.bank_sel);
    assign up_we    = clearing ? (32'(clr_idx) < UPPER_DEPTH) : (wr_acc & wr_loc.bank_sel);
    assign lo_waddr = clearing ? clr_idx : wr_loc.index[LA_W-1:0];
    assign up_waddr = clearing ? clr_idx[UA_W-1:0] : wr_loc.index[UA_W-1:0];
    assign wdata    = clearing ? CLEAR_VALUE : bus.wrData;

    logic [DATA_W-1:0] host_lo_rd;
    logic [DATA_W-1:0] host_up_rd;
    logic [DATA_W-1:0] disp_lo_rd;
    logic [DATA_W-1:0] disp_up_rd;

    vram_bank #(.DATA_W(DATA_W), .DEPTH(LOWER_DEPTH)) u_host_lo (
        .clk(clk), .we_i(lo_we), .waddr_i(lo_waddr), .wdata_i(wdata),
        .re_i(host_acc), .raddr_i(host_loc.index[LA_W-1:0]), .rdata_o(host_lo_rd)
    );

    vram_bank #(.DATA_W(DATA_W), .DEPTH(UPPER_DEPTH)) u_host_up (
        .clk(clk), .we_i(up_we), .waddr_i(up_waddr), .wdata_i(wdata),
        .re_i(host_acc), .raddr_i(host_loc.index[UA_W-1:0]), .rdata_o(host_up_rd)
    );

    vram_bank #(.DATA_W(DATA_W), .DEPTH(LOWER_DEPTH)) u_disp_lo (
        .clk(clk), .we_i(lo_we), .waddr_i(lo_waddr), .wdata_i(wdata),
        .re_i(1'b1), .raddr_i(disp_loc.index[LA_W-1:0]), .rdata_o(disp_lo_rd)
    );

    vram_bank #(.DATA_W(DATA_W), .DEPTH(UPPER_DEPTH)) u_disp_up (
        .clk(clk), .we_i(up_we), .waddr_i(up_waddr), .wdata_i(wdata),
        .re_i(1'b1), .raddr_i(disp_loc.index[UA_W-1:0]), .rdata_o(disp_up_rd)
    );

    logic host_valid_q;
    logic host_sel_q;
    logic host_seen_q;
    logic disp_sel_q;
    logic disp_seen_q;

    // Bank selects are registered alongside the bank read so the mux matches the read stage.
    // The seen flags force zero outputs until a read has actually landed after reset,
    // because the storage copies themselves carry no reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_valid_q <= 1'b0;
            host_sel_q   <= 1'b0;
            host_seen_q  <= 1'b0;
            disp_sel_q   <= 1'b0;
            disp_seen_q  <= 1'b0;
        end else begin
            host_valid_q <= host_acc;
            disp_sel_q   <= disp_loc.bank_sel;
            disp_seen_q  <= 1'b1;
            if (host_acc) begin
                host_sel_q  <= host_loc.bank_sel;
                host_seen_q <= 1'b1;
            end
        end
    end

    assign bus.hostRdValid = host_valid_q;
    assign bus.hostRdData  = host_seen_q ? (host_sel_q ? host_up_rd : host_lo_rd) : '0;
    assign bus.dispRdData  = disp_seen_q ? (disp_sel_q ? disp_up_rd : disp_lo_rd) : '0;
    assign bus.busy        = busy;
    assign bus.wrReady     = wr_ready;
endmodule
